spi_cmd_queue: RTL and testbench

Buffers command bytes from the SPI receiver and presents them as decoded Tetris commands to the game executioner.
- Synchronizes the SPI data_valid level and captures each byte once.
- Drives the SPI clear/invalidate handshake.
- Queues bytes in a small FIFO and hands them downstream with a valid/ready handshake.
- Replaces the direct spi_data→executioner wiring so no command is lost when bytes arrive faster than the game consumes them.

---
 rtl/spi_cmd_queue_if.sv | 52 +++++
 rtl/spi_cmd_queue.sv | 198 +++++++++++++++++++
 tb/tb_spi_cmd_queue.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_queue_if.sv
// Bundles the SPI receiver side and the executioner-side command handshake of spi_cmd_queue.
// The slave modport is the queue itself; the master modport is whatever drives it.
interface spi_cmd_queue_if #(
  parameter int DEPTH = 4
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  // SPI receiver side
  logic [7:0]         spi_data;
  logic               spi_data_valid;
  logic               spi_clear;

  // Executioner side
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_move;
  logic               cmd_move_valid;
  logic [2:0]         cmd_piece;

  // Status / telemetry
  logic [LEVEL_W-1:0] fifo_level;
  logic [7:0]         overflow_count;
  logic [LEVEL_W-1:0] max_level;

  modport slave (
    input  spi_data,
    input  spi_data_valid,
    input  cmd_ready,
    output spi_clear,
    output cmd_valid,
    output cmd_move,
    output cmd_move_valid,
    output cmd_piece,
    output fifo_level,
    output overflow_count,
    output max_level
  );

  modport master (
    output spi_data,
    output spi_data_valid,
    output cmd_ready,
    input  spi_clear,
    input  cmd_valid,
    input  cmd_move,
    input  cmd_move_valid,
    input  cmd_piece,
    input  fifo_level,
    input  overflow_count,
    input  max_level
  );
endinterface

// File: rtl/spi_cmd_queue.sv
// Captures SPI command bytes, acknowledges them with spi_clear and queues them for the game.
// Define SPI_CMD_QUEUE_STATS_EN to build the max_level high-water-mark register.
module spi_cmd_queue #(
  parameter  int DEPTH   = 4,
  localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           reset_n,
  spi_cmd_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  // ---------------------------------------------------------------------------
  // spi_data_valid synchronizer and rising-edge detect
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic valid_s_q;
  logic valid_d_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      valid_s_q <= 1'b0;
      valid_d_q <= 1'b0;
    end else begin
      sync1_q   <= bus.spi_data_valid;
      valid_s_q <= sync1_q;
      valid_d_q <= valid_s_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM: one byte per valid pulse, then hold spi_clear until valid drops
  // ---------------------------------------------------------------------------
  state_e state_q;
  logic   spi_clear_q;
  logic   capture;

  assign capture = valid_s_q && !valid_d_q && (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      spi_clear_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            state_q     <= ST_CLEAR;
            spi_clear_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (!valid_s_q) begin
            state_q     <= ST_IDLE;
            spi_clear_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          spi_clear_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.spi_clear = spi_clear_q;

  // ---------------------------------------------------------------------------
  // Byte classification at capture
  // ---------------------------------------------------------------------------
  logic is_push;
  logic is_flush;

  assign is_push  = capture && !bus.spi_data[7];
  assign is_flush = capture && (bus.spi_data[7:6] == 2'b11);

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [7:0]         ovf_q, ovf_d;
  logic               full;
  logic               pop;
  logic               wr_en;

  assign full = (level_q == FULL_LEVEL);
  assign pop  = bus.cmd_valid && bus.cmd_ready;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;

    if (is_flush) begin
      // Flush outranks a same-edge pop; the accepted head is simply discarded.
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end else begin
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      if (is_push) begin
        if (!full || pop) begin
          wr_en = 1'b1;
          wr_d  = wr_q + 1'b1;
        end else if (ovf_q != 8'hFF) begin
          ovf_d = ovf_q + 1'b1;
        end
      end
      case ({wr_en, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [7:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; entries are only read while the
  // level counter says they were written, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q] <= bus.spi_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Head decode
  // ---------------------------------------------------------------------------
  logic [7:0] head;

  assign head               = mem_q[rd_q];
  assign bus.cmd_valid      = (level_q != '0);
  assign bus.cmd_move       = head[1:0];
  assign bus.cmd_move_valid = head[5];
  // Piece code 7 is not a real piece; the executioner treats it as HERO (0).
  assign bus.cmd_piece      = (head[4:2] == 3'd7) ? 3'd0 : head[4:2];

  assign bus.fifo_level     = level_q;
  assign bus.overflow_count = ovf_q;

  // ---------------------------------------------------------------------------
  // Optional high-water mark
  // ---------------------------------------------------------------------------
`ifdef SPI_CMD_QUEUE_STATS_EN
  logic [LEVEL_W-1:0] max_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_q <= '0;
    end else if (is_flush) begin
      max_q <= '0;
    end else if (level_q > max_q) begin
      max_q <= level_q;
    end
  end

  assign bus.max_level = max_q;
`else
  assign bus.max_level = '0;
`endif

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Self-checking bench for spi_cmd_queue: decode table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_spi_cmd_queue;

  localparam int DEPTH   = 4;
  localparam int LEVEL_W = $clog2(DEPTH) + 1;
  localparam int BOUND   = 12;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  spi_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

  spi_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents of the queue as a list of bytes plus counters.
  logic [7:0] model_q [$];
  int         model_ovf = 0;
  int         model_max = 0;

  typedef struct {
    logic [7:0] data;
    logic       exp_valid;
    logic [1:0] exp_move;
    logic       exp_mv;
    logic [2:0] exp_piece;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_piece(input logic [7:0] b);
    return (b[4:2] == 3'd7) ? 3'd0 : b[4:2];
  endfunction

  function automatic void model_capture(input logic [7:0] b);
    if (b[7] == 1'b0) begin
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else if (model_ovf < 255) model_ovf++;
      if (model_q.size() > model_max) model_max = model_q.size();
    end else if (b[6] == 1'b1) begin
      model_q.delete();
      model_max = 0;
    end
  endfunction

  task automatic check_state(input string name);
    check({name, "/level"}, 32'(bus.fifo_level), 32'(model_q.size()));
    check({name, "/ovf"}, 32'(bus.overflow_count), 32'(model_ovf));
    check({name, "/cmd_valid"}, 32'(bus.cmd_valid), 32'(model_q.size() != 0));
`ifdef SPI_CMD_QUEUE_STATS_EN
    check({name, "/max"}, 32'(bus.max_level), 32'(model_max));
`else
    check({name, "/max"}, 32'(bus.max_level), 32'd0);
`endif
    if (model_q.size() != 0) begin
      check({name, "/move"}, 32'(bus.cmd_move), 32'(model_q[0][1:0]));
      check({name, "/mv"}, 32'(bus.cmd_move_valid), 32'(model_q[0][5]));
      check({name, "/piece"}, 32'(bus.cmd_piece), 32'(ref_piece(model_q[0])));
    end
  endtask

  task automatic wait_clear(input string name, input logic level);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((bus.spi_clear !== level) && (k < BOUND));
    check({name, "/spi_clear_wait"}, 32'(bus.spi_clear), 32'(level));
  endtask

  // Full SPI handshake for one byte with cmd_ready held low.
  task automatic send_byte(input string name, input logic [7:0] b, output int lvl_at_clear);
    @(negedge clk);
    bus.spi_data       = b;
    bus.spi_data_valid = 1'b1;
    wait_clear(name, 1'b1);
    lvl_at_clear = int'(bus.fifo_level);
    bus.spi_data_valid = 1'b0;
    wait_clear(name, 1'b0);
    model_capture(b);
  endtask

  task automatic pop_one(input string name);
    if (model_q.size() != 0) begin
      check({name, "/head_move"}, 32'(bus.cmd_move), 32'(model_q[0][1:0]));
      check({name, "/head_piece"}, 32'(bus.cmd_piece), 32'(ref_piece(model_q[0])));
    end
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  // Push arriving on the same edge as a pop while full.
  task automatic send_with_pop(input string name, input logic [7:0] b);
    @(negedge clk);
    bus.spi_data       = b;
    bus.spi_data_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    void'(model_q.pop_front());
    model_q.push_back(b);
    check({name, "/spi_clear"}, 32'(bus.spi_clear), 32'd1);
    check({name, "/level"}, 32'(bus.fifo_level), 32'(DEPTH));
    check({name, "/ovf"}, 32'(bus.overflow_count), 32'(model_ovf));
    bus.spi_data_valid = 1'b0;
    wait_clear(name, 1'b0);
  endtask

  initial begin
    int lvl;
    logic [7:0] b;

    vecs[0] = '{8'h25, 1'b1, 2'd1, 1'b1, 3'd1};
    vecs[1] = '{8'h1C, 1'b1, 2'd0, 1'b0, 3'd0};
    vecs[2] = '{8'h18, 1'b1, 2'd0, 1'b0, 3'd6};
    vecs[3] = '{8'h3F, 1'b1, 2'd3, 1'b1, 3'd0};
    vecs[4] = '{8'h2A, 1'b1, 2'd2, 1'b1, 3'd2};
    vecs[5] = '{8'h80, 1'b0, 2'd0, 1'b0, 3'd0};
    vecs[6] = '{8'h0B, 1'b1, 2'd3, 1'b0, 3'd2};

    reset_n            = 1'b0;
    bus.spi_data       = 8'h00;
    bus.spi_data_valid = 1'b0;
    bus.cmd_ready      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/spi_clear", 32'(bus.spi_clear), 32'd0);
    check_state("reset");
    reset_n = 1'b1;

    // Capture latency: rise sampled at edge N, captured at edge N+2.
    @(negedge clk);
    bus.spi_data       = 8'h25;
    bus.spi_data_valid = 1'b1;
    @(negedge clk);
    check("lat/after_N", 32'(bus.spi_clear), 32'd0);
    @(negedge clk);
    check("lat/after_N1_clear", 32'(bus.spi_clear), 32'd0);
    check("lat/after_N1_level", 32'(bus.fifo_level), 32'd0);
    @(negedge clk);
    check("lat/after_N2_clear", 32'(bus.spi_clear), 32'd1);
    check("lat/after_N2_valid", 32'(bus.cmd_valid), 32'd1);
    model_capture(8'h25);
    repeat (4) @(negedge clk);
    check("lat/clear_held", 32'(bus.spi_clear), 32'd1);
    bus.spi_data_valid = 1'b0;
    wait_clear("lat", 1'b0);
    check_state("lat");
    pop_one("lat_pop");
    check_state("lat_pop");

    // Decode table, one byte at a time from an empty queue.
    for (int i = 0; i < 7; i++) begin
      send_byte($sformatf("vec%0d", i), vecs[i].data, lvl);
      check($sformatf("vec%0d/valid", i), 32'(bus.cmd_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d/move", i), 32'(bus.cmd_move), 32'(vecs[i].exp_move));
        check($sformatf("vec%0d/mv", i), 32'(bus.cmd_move_valid), 32'(vecs[i].exp_mv));
        check($sformatf("vec%0d/piece", i), 32'(bus.cmd_piece), 32'(vecs[i].exp_piece));
        pop_one($sformatf("vec%0d_pop", i));
      end
      check_state($sformatf("vec%0d_end", i));
    end

    // Overflow: six bytes into a four-entry queue.
    for (int i = 0; i < 6; i++) send_byte("ovf", 8'(i), lvl);
    check("ovf/level", 32'(bus.fifo_level), 32'd4);
    check("ovf/count", 32'(bus.overflow_count), 32'd2);
    check_state("ovf");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain%0d/move", i), 32'(bus.cmd_move), 32'(i));
      pop_one("ovf_drain");
    end
    check_state("ovf_drained");

    // Full with simultaneous push and pop.
    for (int i = 8; i < 12; i++) send_byte("full", 8'(i), lvl);
    send_with_pop("pushpop", 8'h07);
    check_state("pushpop");
    for (int i = 0; i < 3; i++) pop_one("pushpop_drain");
    check("pushpop_last/move", 32'(bus.cmd_move), 32'd3);
    check("pushpop_last/piece", 32'(bus.cmd_piece), 32'd1);
    check("pushpop_last/level", 32'(bus.fifo_level), 32'd1);
    pop_one("pushpop_drain");
    check_state("pushpop_drained");

    // Flush with three queued entries, then a reserved byte.
    for (int i = 0; i < 3; i++) send_byte("pre_flush", 8'h11 + 8'(i), lvl);
    check("pre_flush/level", 32'(bus.fifo_level), 32'd3);
    send_byte("flush", 8'hC0, lvl);
    check("flush/level_next_cycle", 32'(lvl), 32'd0);
    check("flush/cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check_state("flush");
    send_byte("pre_rsv", 8'h21, lvl);
    send_byte("pre_rsv", 8'h22, lvl);
    send_byte("rsv", 8'h80, lvl);
    check("rsv/level", 32'(bus.fifo_level), 32'd2);
    check_state("rsv");

    // Reset while spi_clear is high, valid still high on release.
    @(negedge clk);
    bus.spi_data       = 8'h01;
    bus.spi_data_valid = 1'b1;
    wait_clear("rst_mid", 1'b1);
    model_capture(8'h01);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 0;
    model_max = 0;
    check("rst_mid/spi_clear", 32'(bus.spi_clear), 32'd0);
    check_state("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    wait_clear("rst_release", 1'b1);
    model_capture(8'h01);
    bus.spi_data_valid = 1'b0;
    wait_clear("rst_release", 1'b0);
    repeat (6) @(negedge clk);
    check("rst_release/one_capture", 32'(bus.fifo_level), 32'd1);
    check_state("rst_release");
    pop_one("rst_pop");

    // Randomized traffic against the reference model.
    for (int it = 0; it < 80; it++) begin
      int r;
      int npop;
      r = $urandom_range(0, 11);
      b = 8'($urandom);
      if (r == 0) b = {2'b11, b[5:0]};
      else if (r == 1) b = {2'b10, b[5:0]};
      else b = {1'b0, b[6:0]};
      send_byte("rnd_send", b, lvl);
      check_state($sformatf("rnd%0d_send", it));
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) pop_one("rnd_pop");
      check_state($sformatf("rnd%0d_pop", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
